// File: rtl/sipo_deserializer_32_bit_if.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deserializer_32_bit_if
// Description : Serial input, parallel valid/ready output and status bundle
//               for the SIPO deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sipo_deserializer_32_bit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
);
    logic                  Serial_Data_In;
    logic                  Serial_Valid_In;
    logic                  Frame_Start_In;
    logic [DATA_WIDTH-1:0] Parallel_Data_Out;
    logic                  Parallel_Valid_Out;
    logic                  Parallel_Ready_In;
    logic [CNT_WIDTH-1:0]  Bit_Count_Out;
    logic                  Overrun_Out;
    logic                  Sync_Error_Out;
    logic                  Clear_Flags_In;
    logic                  Parity_Error_Out;

    // Serial producer / parallel consumer side
    modport master (
        output Serial_Data_In, Serial_Valid_In, Frame_Start_In,
        output Parallel_Ready_In, Clear_Flags_In,
        input  Parallel_Data_Out, Parallel_Valid_Out, Bit_Count_Out,
        input  Overrun_Out, Sync_Error_Out, Parity_Error_Out
    );

    // Deserializer side
    modport slave (
        input  Serial_Data_In, Serial_Valid_In, Frame_Start_In,
        input  Parallel_Ready_In, Clear_Flags_In,
        output Parallel_Data_Out, Parallel_Valid_Out, Bit_Count_Out,
        output Overrun_Out, Sync_Error_Out, Parity_Error_Out
    );
endinterface
`default_nettype wire

// File: rtl/sipo_deserializer_32_bit.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deserializer_32_bit
// Description : LSB-first serial-to-parallel deserializer with start-strobe
//               framing, one-word output buffer and sticky error flags.
//               Define SIPO_PARITY_CHECK_EN to add a trailing even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deserializer_32_bit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                        Clk_In,
    input  logic                        Reset_In,
    sipo_deserializer_32_bit_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECEIVE = 2'd1,
        S_PARITY  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] c_FULL = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] c_ONE  = CNT_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ovr_q, ovr_d;
    logic                    sync_q, sync_d;
    logic                    w_complete;
    logic [DATA_WIDTH-1:0]   w_word;
    logic                    w_sync_set;
    logic                    w_ovr_set;
`ifdef SIPO_PARITY_CHECK_EN
    logic                    par_q, par_d;
    logic                    w_par_set;
`endif

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            sync_q  <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            sync_q  <= sync_d;
`ifdef SIPO_PARITY_CHECK_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        count_d    = count_q;
        data_d     = data_q;
        valid_d    = valid_q;
        w_complete = 1'b0;
        w_word     = '0;
        w_sync_set = 1'b0;
        w_ovr_set  = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
        w_par_set  = 1'b0;
`endif

        if (valid_q && bus.Parallel_Ready_In) begin
            valid_d = 1'b0;
        end

        if (bus.Serial_Valid_In) begin
            if (bus.Frame_Start_In) begin
                // A start strobe always opens a fresh frame; mid-frame it is a resync.
                w_sync_set = (state_q != S_IDLE);
                shift_d    = {bus.Serial_Data_In, {(DATA_WIDTH-1){1'b0}}};
                count_d    = c_ONE;
                state_d    = S_RECEIVE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_d = S_IDLE;
                    end
                    S_RECEIVE: begin
                        shift_d = {bus.Serial_Data_In, shift_q[DATA_WIDTH-1:1]};
                        if (count_q == c_LAST) begin
`ifdef SIPO_PARITY_CHECK_EN
                            count_d = c_FULL;
                            state_d = S_PARITY;
`else
                            count_d    = '0;
                            state_d    = S_IDLE;
                            w_complete = 1'b1;
                            w_word     = {bus.Serial_Data_In, shift_q[DATA_WIDTH-1:1]};
`endif
                        end else begin
                            count_d = count_q + c_ONE;
                        end
                    end
`ifdef SIPO_PARITY_CHECK_EN
                    S_PARITY: begin
                        count_d    = '0;
                        state_d    = S_IDLE;
                        w_complete = 1'b1;
                        w_word     = shift_q;
                        w_par_set  = ((^shift_q) != bus.Serial_Data_In);
                    end
`endif
                    default: begin
                        state_d = S_IDLE;
                        count_d = '0;
                    end
                endcase
            end
        end

        // A held word that is not being taken this edge blocks the new one.
        if (w_complete) begin
            if (valid_q && !bus.Parallel_Ready_In) begin
                w_ovr_set = 1'b1;
            end else begin
                data_d  = w_word;
                valid_d = 1'b1;
            end
        end

        ovr_d  = (ovr_q  & ~bus.Clear_Flags_In) | w_ovr_set;
        sync_d = (sync_q & ~bus.Clear_Flags_In) | w_sync_set;
`ifdef SIPO_PARITY_CHECK_EN
        par_d  = (par_q  & ~bus.Clear_Flags_In) | w_par_set;
`endif
    end

    assign bus.Parallel_Data_Out  = data_q;
    assign bus.Parallel_Valid_Out = valid_q;
    assign bus.Bit_Count_Out      = count_q;
    assign bus.Overrun_Out        = ovr_q;
    assign bus.Sync_Error_Out     = sync_q;
`ifdef SIPO_PARITY_CHECK_EN
    assign bus.Parity_Error_Out   = par_q;
`else
    assign bus.Parity_Error_Out   = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_sipo_deserializer_32_bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_deserializer_32_bit
// Description : Directed self-checking bench for sipo_deserializer_32_bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer_32_bit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    sipo_deserializer_32_bit_if #(.DATA_WIDTH(32), .CNT_WIDTH(6)) bus ();

    sipo_deserializer_32_bit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .Clk_In   (clk),
        .Reset_In (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of serial inputs; returns 1 time unit after the edge.
    task automatic bit_cycle(input logic b, input logic v, input logic s);
        bus.Serial_Data_In  = b;
        bus.Serial_Valid_In = v;
        bus.Frame_Start_In  = s;
        @(posedge clk);
        #1;
        bus.Serial_Valid_In = 1'b0;
        bus.Frame_Start_In  = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int first, input int last, input bit start);
        for (int i = first; i <= last; i++) begin
            bit_cycle(w[i], 1'b1, start && (i == first));
        end
    endtask

    task automatic send_parity(input logic [31:0] w);
`ifdef SIPO_PARITY_CHECK_EN
        bit_cycle(^w, 1'b1, 1'b0);
`else
        if (w == 32'h0) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            #0;
        end
        // no parity bit in the default build
        ;
`endif
    endtask

    task automatic send_word(input logic [31:0] w);
        send_bits(w, 0, 31, 1'b1);
`ifdef SIPO_PARITY_CHECK_EN
        send_parity(w);
`endif
    endtask

    logic [31:0] w;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.Serial_Data_In    = 1'b0;
        bus.Serial_Valid_In   = 1'b0;
        bus.Frame_Start_In    = 1'b0;
        bus.Parallel_Ready_In = 1'b1;
        bus.Clear_Flags_In    = 1'b0;

        // Reset state
        bit_cycle(1'b0, 1'b0, 1'b0);
        bit_cycle(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        chk("rst_data",  bus.Parallel_Data_Out, 32'h0);
        chk("rst_valid", 32'(bus.Parallel_Valid_Out), 32'h0);
        chk("rst_count", 32'(bus.Bit_Count_Out), 32'h0);
        chk("rst_flags", {29'h0, bus.Overrun_Out, bus.Sync_Error_Out, bus.Parity_Error_Out}, 32'h0);

        // 1: basic frame
        w = 32'hA5C3_0F81;
        send_bits(w, 0, 0, 1'b1);
        chk("t1_count1", 32'(bus.Bit_Count_Out), 32'd1);
        send_bits(w, 1, 31, 1'b0);
`ifdef SIPO_PARITY_CHECK_EN
        chk("t1_count_full", 32'(bus.Bit_Count_Out), 32'd32);
        send_parity(w);
`endif
        chk("t1_valid", 32'(bus.Parallel_Valid_Out), 32'h1);
        chk("t1_data",  bus.Parallel_Data_Out, 32'hA5C3_0F81);
        chk("t1_count0", 32'(bus.Bit_Count_Out), 32'd0);
        chk("t1_flags", {29'h0, bus.Overrun_Out, bus.Sync_Error_Out, bus.Parity_Error_Out}, 32'h0);
        bit_cycle(1'b0, 1'b0, 1'b0);
        chk("t1_valid_drop", 32'(bus.Parallel_Valid_Out), 32'h0);

        // 2: gapped input
        w = 32'h1234_5678;
        for (int i = 0; i < 32; i++) begin
            bit_cycle(w[i], 1'b1, i == 0);
            if (i == 4) chk("t2_count_on", 32'(bus.Bit_Count_Out), 32'd5);
            if (i != 31) begin
                bit_cycle(1'b1, 1'b0, 1'b1);
                if (i == 4) chk("t2_count_gap", 32'(bus.Bit_Count_Out), 32'd5);
            end
        end
`ifdef SIPO_PARITY_CHECK_EN
        bit_cycle(1'b0, 1'b0, 1'b0);
        send_parity(w);
`endif
        chk("t2_valid", 32'(bus.Parallel_Valid_Out), 32'h1);
        chk("t2_data",  bus.Parallel_Data_Out, 32'h1234_5678);
        bit_cycle(1'b0, 1'b0, 1'b0);

        // 3: backpressure and overrun
        bus.Parallel_Ready_In = 1'b0;
        send_word(32'h0000_0001);
        chk("t3_first_valid", 32'(bus.Parallel_Valid_Out), 32'h1);
        send_word(32'hFFFF_FFFF);
        chk("t3_hold_data", bus.Parallel_Data_Out, 32'h0000_0001);
        chk("t3_overrun", 32'(bus.Overrun_Out), 32'h1);
        bus.Parallel_Ready_In = 1'b1;
        bit_cycle(1'b0, 1'b0, 1'b0);
        chk("t3_valid_drop", 32'(bus.Parallel_Valid_Out), 32'h0);
        chk("t3_overrun_sticky", 32'(bus.Overrun_Out), 32'h1);
        bus.Clear_Flags_In = 1'b1;
        bit_cycle(1'b0, 1'b0, 1'b0);
        bus.Clear_Flags_In = 1'b0;
        chk("t3_overrun_clear", 32'(bus.Overrun_Out), 32'h0);

        // 4: accept and complete on the same edge
        bus.Parallel_Ready_In = 1'b0;
        send_word(32'h0BAD_F00D);
        chk("t4_first_data", bus.Parallel_Data_Out, 32'h0BAD_F00D);
        w = 32'h1357_9BDF;
`ifdef SIPO_PARITY_CHECK_EN
        send_bits(w, 0, 31, 1'b1);
        bus.Parallel_Ready_In = 1'b1;
        send_parity(w);
`else
        send_bits(w, 0, 30, 1'b1);
        bus.Parallel_Ready_In = 1'b1;
        send_bits(w, 31, 31, 1'b0);
`endif
        bus.Parallel_Ready_In = 1'b0;
        chk("t4_second_data", bus.Parallel_Data_Out, 32'h1357_9BDF);
        chk("t4_valid_stays", 32'(bus.Parallel_Valid_Out), 32'h1);
        chk("t4_no_overrun", 32'(bus.Overrun_Out), 32'h0);
        bus.Parallel_Ready_In = 1'b1;
        bit_cycle(1'b0, 1'b0, 1'b0);
        chk("t4_valid_drop", 32'(bus.Parallel_Valid_Out), 32'h0);

        // 5: resync at bit 10, then reset at bit 20
        send_bits(32'hFFFF_FFFF, 0, 9, 1'b1);
        chk("t5_partial_count", 32'(bus.Bit_Count_Out), 32'd10);
        chk("t5_no_sync_yet", 32'(bus.Sync_Error_Out), 32'h0);
        w = 32'hCAFE_BABE;
        send_bits(w, 0, 0, 1'b1);
        chk("t5_sync", 32'(bus.Sync_Error_Out), 32'h1);
        chk("t5_resync_count", 32'(bus.Bit_Count_Out), 32'd1);
        send_bits(w, 1, 31, 1'b0);
`ifdef SIPO_PARITY_CHECK_EN
        send_parity(w);
`endif
        chk("t5_data", bus.Parallel_Data_Out, 32'hCAFE_BABE);
        chk("t5_valid", 32'(bus.Parallel_Valid_Out), 32'h1);
        bus.Parallel_Ready_In = 1'b0;
        send_bits(32'h8765_4321, 0, 19, 1'b1);
        chk("t5_pre_reset_count", 32'(bus.Bit_Count_Out), 32'd20);
        rst = 1'b1;
        bit_cycle(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        chk("t5_reset_data",  bus.Parallel_Data_Out, 32'h0);
        chk("t5_reset_valid", 32'(bus.Parallel_Valid_Out), 32'h0);
        chk("t5_reset_count", 32'(bus.Bit_Count_Out), 32'd0);
        chk("t5_reset_flags", {29'h0, bus.Overrun_Out, bus.Sync_Error_Out, bus.Parity_Error_Out}, 32'h0);
        send_bits(32'h8765_4321, 20, 31, 1'b0);
        chk("t5_nostart_count", 32'(bus.Bit_Count_Out), 32'd0);
        chk("t5_nostart_valid", 32'(bus.Parallel_Valid_Out), 32'h0);
        bus.Parallel_Ready_In = 1'b1;

`ifdef SIPO_PARITY_CHECK_EN
        // 6: parity error detection and clear
        send_bits(32'h0000_0003, 0, 31, 1'b1);
        chk("t6_parity_count", 32'(bus.Bit_Count_Out), 32'd32);
        bit_cycle(1'b1, 1'b1, 1'b0);
        chk("t6_parity_err", 32'(bus.Parity_Error_Out), 32'h1);
        chk("t6_parity_data", bus.Parallel_Data_Out, 32'h0000_0003);
        chk("t6_parity_valid", 32'(bus.Parallel_Valid_Out), 32'h1);
        bus.Clear_Flags_In = 1'b1;
        bit_cycle(1'b0, 1'b0, 1'b0);
        bus.Clear_Flags_In = 1'b0;
        chk("t6_parity_clear", 32'(bus.Parity_Error_Out), 32'h0);
        send_bits(32'h0000_0003, 0, 31, 1'b1);
        bit_cycle(1'b0, 1'b1, 1'b0);
        chk("t6_parity_ok", 32'(bus.Parity_Error_Out), 32'h0);
        chk("t6_parity_ok_valid", 32'(bus.Parallel_Valid_Out), 32'h1);
`else
        chk("t6_parity_tied", 32'(bus.Parity_Error_Out), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
